// File: rtl/mem_stage_hs.sv
// mem_stage_hs: handshaked MEM stage. Registers one EX result, issues at most one
// data-memory access via req/gnt and rvalid, then presents one WB result.
module mem_stage_hs #(
  parameter int XLEN          = 32,
  parameter int ADDR_W        = 32,
  parameter bit MISALIGN_TRAP = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [4:0]        i_rd_addr,
  input  logic              i_rd_wr,
  input  logic [XLEN-1:0]   i_alu_out,
  input  logic [XLEN-1:0]   i_rs2_data,
  input  logic              i_load,
  input  logic              i_store,
  input  logic [2:0]        i_funct3,
  output logic              o_valid,
  output logic [4:0]        o_rd_addr,
  output logic              o_rd_wr,
  output logic [XLEN-1:0]   o_wb_data,
  output logic              o_misalign,
  output logic              o_stall,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [XLEN/8-1:0] dm_web,
  output logic [XLEN-1:0]   dm_wdata,
  input  logic              dm_gnt,
  input  logic              dm_rvalid,
  input  logic [XLEN-1:0]   dm_rdata
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t state, state_nxt;

  logic             accept;
  logic             is_mem;
  logic             illegal;
  logic             misal;
  logic             trap;
  logic [1:0]       sz;
  logic [3:0]       lowmask4;
  logic [OFF_W-1:0] sz_lowmask;
  logic [OFF_W-1:0] off_raw;
  logic [OFF_W-1:0] off_eff;

  logic [4:0]       rd_addr_p1;
  logic             rd_wr_p1;
  logic [2:0]       funct3_p1;
  logic [OFF_W-1:0] off_p1;
  logic [XLEN-1:0]  alu_p1;

  // Byte-lane mask for an access of 2**sz bytes starting at lane 0.
  function automatic logic [NB-1:0] byte_mask(input logic [1:0] s);
    logic [7:0] m;
    case (s)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m[NB-1:0];
  endfunction

  // Replicate the low 2**s bytes of the store data across the whole bus.
  function automatic logic [XLEN-1:0] store_rep(input logic [XLEN-1:0] d, input logic [1:0] s);
    logic [XLEN-1:0] r;
    int              n;
    n = 1 << s;
    r = '0;
    for (int k = 0; k < NB; k++) r[k*8 +: 8] = d[(k % n)*8 +: 8];
    return r;
  endfunction

  // Pick the addressed bytes out of the returned word and sign/zero-extend them.
  function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] rdata,
                                                   input logic [2:0]      f3,
                                                   input logic [OFF_W-1:0] off);
    logic        [XLEN-1:0] sh;
    logic signed [7:0]      sb;
    logic signed [15:0]     shw;
    logic signed [31:0]     sw;
    logic        [XLEN-1:0] r;
    sh  = rdata >> {off, 3'b000};
    sb  = sh[7:0];
    shw = sh[15:0];
    sw  = sh[31:0];
    case (f3)
      3'b000:  r = XLEN'(sb);
      3'b001:  r = XLEN'(shw);
      3'b010:  r = XLEN'(sw);
      3'b100:  r = XLEN'(sh[7:0]);
      3'b101:  r = XLEN'(sh[15:0]);
      3'b110:  r = XLEN'(sh[31:0]);
      default: r = sh;
    endcase
    return r;
  endfunction

  assign accept  = i_valid && (state == S_IDLE);
  assign o_ready = (state == S_IDLE);
  assign o_stall = ~o_ready;
  assign dm_req  = (state == S_REQ);

  // Decode size, alignment and legality of the instruction on the inputs.
  always_comb begin
    is_mem     = i_load | i_store;
    sz         = i_funct3[1:0];
    lowmask4   = 4'((4'd1 << sz) - 4'd1);
    sz_lowmask = lowmask4[OFF_W-1:0];
    off_raw    = i_alu_out[OFF_W-1:0];
    off_eff    = off_raw & ~sz_lowmask;
    misal      = |(off_raw & sz_lowmask);
    illegal    = (i_funct3 == 3'b111) ||
                 ((XLEN == 32) && ((i_funct3 == 3'b011) || (i_funct3 == 3'b110)));
    trap       = is_mem && (illegal || (misal && MISALIGN_TRAP));
  end

  // Next-state logic of the access sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && is_mem && !trap) state_nxt = S_REQ;
      S_REQ:   if (dm_gnt) state_nxt = dm_we ? S_IDLE : S_WAIT;
      S_WAIT:  if (dm_rvalid) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register; async reset abandons any outstanding access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // ---- stage p1: capture the accepted instruction for later WB ----
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_addr_p1 <= i_rd_addr;
      rd_wr_p1   <= i_rd_wr;
      funct3_p1  <= i_funct3;
      off_p1     <= off_eff;
      alu_p1     <= i_alu_out;
    end
  end

  // ---- stage p2: memory interface registers and registered WB outputs ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_valid    <= 1'b0;
      o_misalign <= 1'b0;
      o_rd_addr  <= '0;
      o_rd_wr    <= 1'b0;
      o_wb_data  <= '0;
      dm_we      <= 1'b0;
      dm_addr    <= '0;
      dm_web     <= '1;
      dm_wdata   <= '0;
    end else begin
      o_valid    <= 1'b0;
      o_misalign <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (!is_mem || trap) begin
              o_valid    <= 1'b1;
              o_misalign <= trap;
              o_rd_addr  <= i_rd_addr;
              o_rd_wr    <= i_rd_wr && !is_mem;
              o_wb_data  <= i_alu_out;
            end else begin
              dm_we   <= i_store;
              dm_addr <= {i_alu_out[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              if (i_store) begin
                dm_web   <= ~(byte_mask(sz) << off_eff);
                dm_wdata <= store_rep(i_rs2_data, sz);
              end else begin
                dm_web   <= '1;
              end
            end
          end
        end
        S_REQ: begin
          if (dm_gnt && dm_we) begin
            o_valid   <= 1'b1;
            o_rd_addr <= rd_addr_p1;
            o_rd_wr   <= 1'b0;
            o_wb_data <= alu_p1;
          end
        end
        S_WAIT: begin
          if (dm_rvalid) begin
            o_valid   <= 1'b1;
            o_rd_addr <= rd_addr_p1;
            o_rd_wr   <= rd_wr_p1;
            o_wb_data <= load_extract(dm_rdata, funct3_p1, off_p1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
